// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output V is built when SERIAL_ADDSUB_OVF_EN is defined.
`default_nettype none

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   last;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [31:0]      base;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT:0]   slice_sum;

  // Subtraction is folded in at acceptance: B and the carry are stored pre-inverted.
  assign base      = 32'(cnt) * 32'(DIGIT);
  assign a_sl      = a_q[base +: DIGIT];
  assign b_sl      = b_q[base +: DIGIT];
  assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == LAST);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      V     <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= A;
      b_q   <= sub ? ~B : B;
      carry <= Cin ^ sub;
      cnt   <= '0;
      S     <= '0;
    end else if (state == RUN) begin
      S[base +: DIGIT] <= slice_sum[DIGIT-1:0];
      carry            <= slice_sum[DIGIT];
      cnt              <= cnt + CW'(1);
      if (last) begin
        Cout <= slice_sum[DIGIT];
`ifdef SERIAL_ADDSUB_OVF_EN
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        V    <= (slice_sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1]) ^ slice_sum[DIGIT];
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks of serial_addsub at WIDTH=8/DIGIT=1, WIDTH=16/DIGIT=4 and WIDTH=4/DIGIT=1,2,4.
`default_nettype none

module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 8-bit, 1 bit per cycle
  logic       start8, sub8, cin8, busy8, done8, cout8, v8;
  logic [7:0] a8, b8, s8;
  // 16-bit, 4 bits per cycle
  logic        start16, sub16, cin16, busy16, done16, cout16, v16;
  logic [15:0] a16, b16, s16;
  // 4-bit instances share stimulus
  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4_1, done4_1, cout4_1, v4_1;
  logic       busy4_2, done4_2, cout4_2, v4_2;
  logic       busy4_4, done4_4, cout4_4, v4_4;
  logic [3:0] s4_1, s4_2, s4_4;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .V(v8)
`endif
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .A(a16), .B(b16), .Cin(cin16),
    .busy(busy16), .done(done16), .S(s16), .Cout(cout16)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .V(v16)
`endif
  );

  serial_addsub #(.WIDTH(4), .DIGIT(1)) u4_1 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4_1), .done(done4_1), .S(s4_1), .Cout(cout4_1)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .V(v4_1)
`endif
  );

  serial_addsub #(.WIDTH(4), .DIGIT(2)) u4_2 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4_2), .done(done4_2), .S(s4_2), .Cout(cout4_2)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .V(v4_2)
`endif
  );

  serial_addsub #(.WIDTH(4), .DIGIT(4)) u4_4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4_4), .done(done4_4), .S(s4_4), .Cout(cout4_4)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .V(v4_4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb,
                     input logic [7:0] es, input logic ec, input logic ev);
    int n;
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~ci; sub8 = ~sb;
    n = 0;
    while (!done8 && n < 20) begin
      chk({tag, "_busy"}, busy8, 1);
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_S"}, s8, es);
    chk({tag, "_Cout"}, cout8, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, "_V"}, v8, ev);
`endif
    step();
    chk({tag, "_done_pulse"}, done8, 0);
    chk({tag, "_S_held"}, s8, es);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb,
                      input logic [15:0] es, input logic ec, input logic ev);
    int n;
    a16 = a; b16 = b; cin16 = ci; sub16 = sb; start16 = 1'b1;
    step();
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_S"}, s16, es);
    chk({tag, "_Cout"}, cout16, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, "_V"}, v16, ev);
`endif
    step();
  endtask

  logic [7:0] bb_a   [3] = '{8'h12, 8'h80, 8'hC8};
  logic [7:0] bb_b   [3] = '{8'h34, 8'h01, 8'h64};
  logic       bb_c   [3] = '{1'b0, 1'b0, 1'b1};
  logic       bb_sub [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] bb_s   [3] = '{8'h46, 8'h7F, 8'h2D};
  logic       bb_co  [3] = '{1'b0, 1'b1, 1'b1};
  logic       bb_v   [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int dones;
    int ea, eb, ec, full, sres, sa, sb, es, ecout, ev;
    int d1, d2, d4;

    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
    start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;
    step();
    step();
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_S", s8, 0);
    chk("rst_Cout", cout8, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy8, 0);

    op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op8("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8("sub_01_01_b", 8'h01, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

    op16("w16_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("w16_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("w16_sub", 16'h1234, 16'h1235, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Start held high: each operation accepted in the DONE cycle of the previous one.
    a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0]; sub8 = bb_sub[0]; start8 = 1'b1;
    step();
    for (int j = 0; j < 3; j++) begin
      if (j < 2) begin
        a8 = bb_a[j+1]; b8 = bb_b[j+1]; cin8 = bb_c[j+1]; sub8 = bb_sub[j+1];
      end else begin
        start8 = 1'b0;
      end
      for (int t = 0; t < 8; t++) begin
        chk($sformatf("b2b%0d_done_early", j), done8, 0);
        step();
      end
      chk($sformatf("b2b%0d_done", j), done8, 1);
      chk($sformatf("b2b%0d_S", j), s8, bb_s[j]);
      chk($sformatf("b2b%0d_Cout", j), cout8, bb_co[j]);
`ifdef SERIAL_ADDSUB_OVF_EN
      chk($sformatf("b2b%0d_V", j), v8, bb_v[j]);
`endif
      step();
    end
    chk("b2b_end_busy", busy8, 0);

    // Reset in the third RUN cycle aborts the operation.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 0; sub8 = 0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    chk("abort_busy_before", busy8, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_S", s8, 0);
    chk("abort_Cout", cout8, 0);
    dones = 0;
    for (int t = 0; t < 12; t++) begin
      if (done8) dones++;
      step();
    end
    chk("abort_no_done", dones, 0);
    op8("after_abort", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

    // Exhaustive 4-bit sweep against an arithmetic model.
    for (int k = 0; k < 1024; k++) begin
      ea = k & 15; eb = (k >> 4) & 15; ec = (k >> 8) & 1;
      sa = (ea >= 8) ? ea - 16 : ea;
      sb = (eb >= 8) ? eb - 16 : eb;
      if (((k >> 9) & 1) == 1) begin
        full = ea + ((~eb) & 15) + (1 - ec);
        sres = sa - sb - ec;
      end else begin
        full = ea + eb + ec;
        sres = sa + sb + ec;
      end
      es = full & 15;
      ecout = (full >> 4) & 1;
      ev = (sres < -8 || sres > 7) ? 1 : 0;
      a4 = 4'(ea); b4 = 4'(eb); cin4 = ec[0]; sub4 = k[9]; start4 = 1'b1;
      step();
      start4 = 1'b0;
      d1 = -1; d2 = -1; d4 = -1;
      for (int t = 1; t <= 5; t++) begin
        step();
        if (done4_1) begin
          d1 = t;
          chk($sformatf("x%0d_d1_S", k), s4_1, es);
          chk($sformatf("x%0d_d1_Cout", k), cout4_1, ecout);
`ifdef SERIAL_ADDSUB_OVF_EN
          chk($sformatf("x%0d_d1_V", k), v4_1, ev);
`endif
        end
        if (done4_2) begin
          d2 = t;
          chk($sformatf("x%0d_d2_S", k), s4_2, es);
          chk($sformatf("x%0d_d2_Cout", k), cout4_2, ecout);
`ifdef SERIAL_ADDSUB_OVF_EN
          chk($sformatf("x%0d_d2_V", k), v4_2, ev);
`endif
        end
        if (done4_4) begin
          d4 = t;
          chk($sformatf("x%0d_d4_S", k), s4_4, es);
          chk($sformatf("x%0d_d4_Cout", k), cout4_4, ecout);
`ifdef SERIAL_ADDSUB_OVF_EN
          chk($sformatf("x%0d_d4_V", k), v4_4, ev);
`endif
        end
      end
      chk($sformatf("x%0d_lat1", k), d1, 4);
      chk($sformatf("x%0d_lat2", k), d2, 2);
      chk($sformatf("x%0d_lat4", k), d4, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
